data_mem_arbiter: RTL and testbench

Two-master arbiter that shares the single `DataMemory` port (AddressBus / DataBusOut / DataBusIn / ControlBus) between the CPU data port and a DMA/loader port. It sits between the `CPU` bus outputs and `DataMemory`. It uses a registered, parking grant with starvation bounding and DMA burst locking. It also produces a stall for the CPU whenever the CPU requests without owning the bus.

---
 rtl/data_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-master (CPU / DMA) arbiter in front of the single DataMemory port.
// Optional build macro ARB_ROUND_ROBIN_EN: CPU->DMA hand-over on any DMA request.
module data_mem_arbiter #(
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic          InputClk,
    input  logic          rst,
    input  logic [DW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [2:0]    cpu_ctrl,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic [DW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic [2:0]    dma_ctrl,
    input  logic          dma_lock,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          owner,
    output logic [DW-1:0] AddressBus,
    output logic [DW-1:0] DataBusOut,
    output logic [2:0]    ControlBus,
    input  logic [DW-1:0] DataBusIn
);

    localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    owner_t               owner_q, owner_d;
    logic [WAIT_W-1:0]    dma_wait_q, dma_wait_d;
    logic [BURST_W-1:0]   burst_q, burst_d;

    logic                 cpu_req, dma_req, dma_own;
    logic [2:0]           sel_ctrl;
    logic                 sel_req;
    logic                 unused_ctrl_bits;

    assign cpu_req = cpu_ctrl[1] | cpu_ctrl[2];
    assign dma_req = dma_ctrl[1] | dma_ctrl[2];
    assign dma_own = (owner_q == OWN_DMA);
    assign unused_ctrl_bits = cpu_ctrl[0] ^ dma_ctrl[0];

    // Grant and counter registers
    always_ff @(posedge InputClk or negedge rst) begin
        if (!rst) begin
            owner_q    <= OWN_CPU;
            dma_wait_q <= '0;
            burst_q    <= '0;
        end else begin
            owner_q    <= owner_d;
            dma_wait_q <= dma_wait_d;
            burst_q    <= burst_d;
        end
    end

    // Next owner: parking grant, starvation bound for DMA, lock-bounded DMA bursts
    always_comb begin
        owner_d    = owner_q;
        dma_wait_d = dma_wait_q;
        burst_d    = burst_q;

        if (owner_q == OWN_CPU) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (dma_req) owner_d = OWN_DMA;
`else
            if (dma_req && (!cpu_req || dma_wait_q >= WAIT_W'(MAX_WAIT - 1))) owner_d = OWN_DMA;
`endif
        end else begin
            if (cpu_req && !(dma_req && dma_lock && burst_q < BURST_W'(MAX_BURST - 1)))
                owner_d = OWN_CPU;
        end

        if (owner_q == OWN_CPU && owner_d == OWN_DMA) begin
            dma_wait_d = '0;
            burst_d    = '0;
        end else begin
            if (owner_q == OWN_CPU && dma_req && dma_wait_q < WAIT_W'(MAX_WAIT))
                dma_wait_d = dma_wait_q + WAIT_W'(1);
            if (owner_q == OWN_DMA && dma_req && burst_q < BURST_W'(MAX_BURST))
                burst_d = burst_q + BURST_W'(1);
        end

`ifdef ARB_ROUND_ROBIN_EN
        dma_wait_d = '0;
`endif
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic unused_wait;
    assign unused_wait = |dma_wait_q;
`endif

    // Bus mux follows the registered owner; write wins over read on ControlBus
    always_comb begin
        if (dma_own) begin
            AddressBus = dma_addr;
            DataBusOut = dma_wdata;
            sel_ctrl   = dma_ctrl;
            sel_req    = dma_req;
            cpu_rdata  = '0;
            dma_rdata  = DataBusIn;
        end else begin
            AddressBus = cpu_addr;
            DataBusOut = cpu_wdata;
            sel_ctrl   = cpu_ctrl;
            sel_req    = cpu_req;
            cpu_rdata  = DataBusIn;
            dma_rdata  = '0;
        end
        ControlBus = (rst && sel_req) ? {sel_ctrl[2], sel_ctrl[1] & ~sel_ctrl[2], 1'b0} : 3'b000;
    end

    assign owner     = dma_own;
    assign cpu_ack   = rst & cpu_req & ~dma_own;
    assign dma_ack   = rst & dma_req & dma_own;
    assign cpu_stall = rst & cpu_req & dma_own;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small DataMemory model.
module tb_data_mem_arbiter;

    localparam int unsigned DW = 32;

    logic          InputClk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] cpu_addr = '0, cpu_wdata = '0;
    logic [2:0]    cpu_ctrl = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack, cpu_stall;
    logic [DW-1:0] dma_addr = '0, dma_wdata = '0;
    logic [2:0]    dma_ctrl = '0;
    logic          dma_lock = 1'b0;
    logic [DW-1:0] dma_rdata;
    logic          dma_ack, owner;
    logic [DW-1:0] AddressBus, DataBusOut, DataBusIn;
    logic [2:0]    ControlBus;

    logic [DW-1:0] mem [0:255];
    int total = 0;
    int bad = 0;

    data_mem_arbiter dut (
        .InputClk(InputClk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ctrl(cpu_ctrl),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ctrl(dma_ctrl),
        .dma_lock(dma_lock), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .owner(owner), .AddressBus(AddressBus), .DataBusOut(DataBusOut),
        .ControlBus(ControlBus), .DataBusIn(DataBusIn)
    );

    always #5 InputClk = ~InputClk;

    // Memory model: combinational read, write on the falling edge
    assign DataBusIn = mem[AddressBus[7:0]];
    always @(negedge InputClk) if (ControlBus[2]) mem[AddressBus[7:0]] <= DataBusOut;

    task automatic tick();
        @(posedge InputClk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_ctrl = 3'b000;
        dma_ctrl = 3'b000;
        dma_lock = 1'b0;
    endtask

    task automatic reset_dut();
        tick();
        rst = 1'b0;
        idle_inputs();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        cpu_ctrl = 3'b100;
        dma_ctrl = 3'b010;
        dma_lock = 1'b1;
        tick();
        #2;
        total++; if (ControlBus !== 3'b000) begin bad++; $display("FAIL reset_ctrl got=%b want=000", ControlBus); end
        total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL reset_cpu_ack got=%b want=0", cpu_ack); end
        total++; if (dma_ack !== 1'b0) begin bad++; $display("FAIL reset_dma_ack got=%b want=0", dma_ack); end
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", cpu_stall); end
        total++; if (owner !== 1'b0) begin bad++; $display("FAIL reset_owner got=%b want=0", owner); end
        idle_inputs();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_cpu_write_read();
        tick();
        cpu_ctrl = 3'b100; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        #2;
        total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL cpu_wr_ack got=%b want=1", cpu_ack); end
        total++; if (ControlBus !== 3'b100) begin bad++; $display("FAIL cpu_wr_ctrl got=%b want=100", ControlBus); end
        total++; if (AddressBus !== 32'h10) begin bad++; $display("FAIL cpu_wr_addr got=%h want=10", AddressBus); end
        total++; if (DataBusOut !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_wr_data got=%h want=deadbeef", DataBusOut); end
        tick();
        cpu_ctrl = 3'b010;
        #2;
        total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_rd_data got=%h want=deadbeef", cpu_rdata); end
        total++; if (ControlBus !== 3'b010) begin bad++; $display("FAIL cpu_rd_ctrl got=%b want=010", ControlBus); end
        total++; if (dma_rdata !== 32'h0) begin bad++; $display("FAIL cpu_rd_dma_rdata got=%h want=0", dma_rdata); end
    endtask

    task automatic test_dma_only();
        tick();
        cpu_ctrl = 3'b000; dma_ctrl = 3'b010; dma_addr = 32'h10;
        #2;
        total++; if (dma_ack !== 1'b0) begin bad++; $display("FAIL dma_c0_ack got=%b want=0", dma_ack); end
        total++; if (owner !== 1'b0) begin bad++; $display("FAIL dma_c0_owner got=%b want=0", owner); end
        total++; if (ControlBus !== 3'b000) begin bad++; $display("FAIL dma_c0_ctrl got=%b want=000", ControlBus); end
        tick();
        #2;
        total++; if (owner !== 1'b1) begin bad++; $display("FAIL dma_c1_owner got=%b want=1", owner); end
        total++; if (dma_ack !== 1'b1) begin bad++; $display("FAIL dma_c1_ack got=%b want=1", dma_ack); end
        total++; if (dma_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL dma_c1_rdata got=%h want=deadbeef", dma_rdata); end
        total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL dma_c1_cpu_rdata got=%h want=0", cpu_rdata); end
        tick();
        dma_ctrl = 3'b000;
        #2;
        total++; if (owner !== 1'b1) begin bad++; $display("FAIL dma_park_owner got=%b want=1", owner); end
        total++; if (ControlBus !== 3'b000) begin bad++; $display("FAIL dma_park_ctrl got=%b want=000", ControlBus); end
    endtask

    task automatic test_contention();
        logic exp_cpu;
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) begin
                cpu_ctrl = 3'b010; cpu_addr = 32'h10;
                dma_ctrl = 3'b010; dma_addr = 32'h20; dma_lock = 1'b0;
            end
            #2;
`ifdef ARB_ROUND_ROBIN_EN
            exp_cpu = (i % 2 == 0);
`else
            exp_cpu = (i % 5 != 4);
`endif
            total++; if (cpu_ack !== exp_cpu) begin bad++; $display("FAIL cont_cpu_ack[%0d] got=%b want=%b", i, cpu_ack, exp_cpu); end
            total++; if (dma_ack !== !exp_cpu) begin bad++; $display("FAIL cont_dma_ack[%0d] got=%b want=%b", i, dma_ack, !exp_cpu); end
            total++; if (cpu_stall !== !exp_cpu) begin bad++; $display("FAIL cont_stall[%0d] got=%b want=%b", i, cpu_stall, !exp_cpu); end
        end
    endtask

    task automatic test_locked_burst();
        logic exp_dma;
        reset_dut();
        tick();
        dma_ctrl = 3'b100; dma_addr = 32'h30; dma_wdata = 32'hA5A5A5A5; dma_lock = 1'b1;
        #2;
        total++; if (dma_ack !== 1'b0) begin bad++; $display("FAIL burst_pre_ack got=%b want=0", dma_ack); end
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 0) begin cpu_ctrl = 3'b010; cpu_addr = 32'h10; end
            #2;
            exp_dma = (i < 8);
            total++; if (dma_ack !== exp_dma) begin bad++; $display("FAIL burst_dma_ack[%0d] got=%b want=%b", i, dma_ack, exp_dma); end
            total++; if (cpu_ack !== !exp_dma) begin bad++; $display("FAIL burst_cpu_ack[%0d] got=%b want=%b", i, cpu_ack, !exp_dma); end
            total++; if (cpu_stall !== exp_dma) begin bad++; $display("FAIL burst_stall[%0d] got=%b want=%b", i, cpu_stall, exp_dma); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        int j;
        reset_dut();
        tick();
        dma_ctrl = 3'b100; dma_addr = 32'h34; dma_wdata = 32'h1; dma_lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) cpu_ctrl = 3'b010;
            #2;
            total++; if (dma_ack !== 1'b1) begin bad++; $display("FAIL midrst_burst[%0d] got=%b want=1", i, dma_ack); end
        end
        tick();
        rst = 1'b0;
        #1;
        total++; if (ControlBus !== 3'b000) begin bad++; $display("FAIL midrst_ctrl got=%b want=000", ControlBus); end
        total++; if (dma_ack !== 1'b0) begin bad++; $display("FAIL midrst_dma_ack got=%b want=0", dma_ack); end
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL midrst_stall got=%b want=0", cpu_stall); end
        total++; if (owner !== 1'b0) begin bad++; $display("FAIL midrst_owner got=%b want=0", owner); end
        tick();
        rst = 1'b1;
        cpu_ctrl = 3'b000;
        #2;
        total++; if (owner !== 1'b0) begin bad++; $display("FAIL postrst_owner got=%b want=0", owner); end
        total++; if (dma_ack !== 1'b0) begin bad++; $display("FAIL postrst_dma_ack got=%b want=0", dma_ack); end
        tick();
        cpu_ctrl = 3'b010;
        #2;
        n = 0;
        j = 0;
        while (cpu_ack !== 1'b1 && j < 16) begin
            if (dma_ack === 1'b1) n++;
            tick();
            #2;
            j++;
        end
        total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL postrst_cpu_timeout got=%b want=1", cpu_ack); end
        total++; if (n != 8) begin bad++; $display("FAIL postrst_burst_len got=%0d want=8", n); end
    endtask

    task automatic test_illegal_ctrl();
        reset_dut();
        tick();
        cpu_ctrl = 3'b110; cpu_addr = 32'h40; cpu_wdata = 32'h12345678;
        #2;
        total++; if (ControlBus !== 3'b100) begin bad++; $display("FAIL illegal_ctrl got=%b want=100", ControlBus); end
        total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL illegal_ack got=%b want=1", cpu_ack); end
        tick();
        cpu_ctrl = 3'b010;
        #2;
        total++; if (cpu_rdata !== 32'h12345678) begin bad++; $display("FAIL illegal_readback got=%h want=12345678", cpu_rdata); end
        tick();
        idle_inputs();
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = '0;
        test_reset();
        test_cpu_write_read();
        test_dma_only();
        test_contention();
        test_locked_burst();
        test_reset_mid_burst();
        test_illegal_ctrl();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
